// File: rtl/wash_pkg.sv
// Shared encodings and field widths for the washer mode controller and the
// run/countdown controller that consumes its state bus.
package wash_pkg;

  localparam int STATE_W = 3;
  localparam int TIME_W  = 3;
  localparam int MSG_W   = 26;

  // Operating modes carried on the state bus; code 7 is unused.
  typedef enum logic [STATE_W-1:0] {
    ST_SHUTDOWN = 3'd0,
    ST_BEGIN    = 3'd1,
    ST_SET      = 3'd2,
    ST_RUN      = 3'd3,
    ST_ERROR    = 3'd4,
    ST_PAUSE    = 3'd5,
    ST_FINISH   = 3'd6
  } state_t;

  // Modes that drive the front-panel indicators.
  function automatic logic is_alarm_state(input state_t s);
    return (s == ST_FINISH);
  endfunction

  function automatic logic is_err_state(input state_t s);
    return (s == ST_ERROR);
  endfunction

endpackage

// File: rtl/in_conditioner.sv
// Conditions one raw board input: two-flop synchronizer, debouncer and a
// single-cycle pulse on each rising edge of the debounced level.
module in_conditioner #(
  parameter int DEBOUNCE_CYCLES = 5000,
  parameter int CNT_W           = 13
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_rem;

  // Two-flop synchronizer for the asynchronous raw input.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // Remaining differing samples still needed after this one; a zero count
  // means no candidate change is in progress, so the first sample reloads.
  always_comb begin
    cnt_rem = '0;
    if (cnt == '0) cnt_rem = CNT_LOAD;
    else           cnt_rem = cnt - 1'b1;
  end

  // Down-counter debouncer: the level flips when the terminal count is hit
  // on consecutive differing samples; any agreeing sample aborts the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
    end else begin
      rise <= 1'b0;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt_rem == '0) begin
        level <= sync2;
        rise  <= sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt_rem;
      end
    end
  end

endmodule

// File: rtl/wash_state_ctrl.sv
// Top-level operating-mode FSM of the washing machine. Conditions the power,
// start/pause and lid inputs and drives the mode bus for the run controller.
//
// state       | meaning
// ------------+------------------------------------------------------------
// ST_SHUTDOWN | machine off, only a power press is honoured
// ST_BEGIN    | power-on countdown running in the run controller
// ST_SET      | waiting for start with the lid closed
// ST_RUN      | wash cycle in progress
// ST_ERROR    | lid opened where not allowed, waits for lid to close
// ST_PAUSE    | wash suspended by start/pause, lid may be opened
// ST_FINISH   | cycle complete, alarm on until the finish countdown ends
module wash_state_ctrl
  import wash_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 5000,
  parameter int CNT_W           = 13
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               power_btn,
  input  logic               start_btn,
  input  logic               lid_open,
  input  logic [TIME_W-1:0]  initTime,
  input  logic [TIME_W-1:0]  finishTime,
  input  logic               hadFinish,
  output logic [STATE_W-1:0] state,
  output logic               alarm,
  output logic               err_led
);

  logic   power_lvl;
  logic   power_pulse;
  logic   start_lvl;
  logic   start_pulse;
  logic   lid_db;
  logic   lid_rise_unused;

  state_t st;
  state_t st_nxt;
  state_t ret_st;
  state_t ret_nxt;

  in_conditioner #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_power (
    .clk  (clk),
    .rst  (rst),
    .raw  (power_btn),
    .level(power_lvl),
    .rise (power_pulse)
  );

  in_conditioner #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_start (
    .clk  (clk),
    .rst  (rst),
    .raw  (start_btn),
    .level(start_lvl),
    .rise (start_pulse)
  );

  // The lid is consumed as a level; its edge pulse has no user.
  in_conditioner #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_lid (
    .clk  (clk),
    .rst  (rst),
    .raw  (lid_open),
    .level(lid_db),
    .rise (lid_rise_unused)
  );

  // Next-mode and error-return selection; power always wins, then the
  // per-mode priorities (lid over hadFinish over start while running).
  always_comb begin
    st_nxt  = st;
    ret_nxt = ret_st;
    if (power_pulse && (st != ST_SHUTDOWN)) begin
      st_nxt = ST_SHUTDOWN;
    end else begin
      case (st)
        ST_SHUTDOWN: begin
          if (power_pulse) st_nxt = ST_BEGIN;
        end
        ST_BEGIN: begin
          if (initTime == '0) st_nxt = ST_SET;
        end
        ST_SET: begin
          if (start_pulse) begin
            if (lid_db) begin
              st_nxt  = ST_ERROR;
              ret_nxt = ST_SET;
            end else begin
              st_nxt = ST_RUN;
            end
          end
        end
        ST_RUN: begin
          if (lid_db) begin
            st_nxt  = ST_ERROR;
            ret_nxt = ST_PAUSE;
          end else if (hadFinish) begin
            st_nxt = ST_FINISH;
          end else if (start_pulse) begin
            st_nxt = ST_PAUSE;
          end
        end
        ST_PAUSE: begin
          if (start_pulse && !lid_db) st_nxt = ST_RUN;
        end
        ST_ERROR: begin
          // A start press coinciding with the lid closing is dropped here.
          if (!lid_db) st_nxt = ret_st;
        end
        ST_FINISH: begin
          if (finishTime == '0) st_nxt = ST_SHUTDOWN;
        end
        default: begin
          st_nxt = ST_SHUTDOWN;
        end
      endcase
    end
  end

  // Mode register with indicator decodes of the next mode, so the lamps
  // switch on the same edge as the mode bus.
  always_ff @(posedge clk) begin
    if (rst) begin
      st      <= ST_SHUTDOWN;
      ret_st  <= ST_SET;
      alarm   <= 1'b0;
      err_led <= 1'b0;
    end else begin
      st      <= st_nxt;
      ret_st  <= ret_nxt;
      alarm   <= is_alarm_state(st_nxt);
      err_led <= is_err_state(st_nxt);
    end
  end

  assign state = st;

endmodule

// File: tb/tb_wash_state_ctrl.sv
// Bench for wash_state_ctrl: directed button/sensor sequences with a queue of
// expected {state, alarm, err_led} tuples checked by an independent monitor.
module tb_wash_state_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       power_btn = 1'b0;
  logic       start_btn = 1'b0;
  logic       lid_open = 1'b0;
  logic [2:0] initTime = 3'd7;
  logic [2:0] finishTime = 3'd7;
  logic       hadFinish = 1'b0;
  logic [2:0] state;
  logic       alarm;
  logic       err_led;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_change_cyc = 0;
  int t0;
  bit mon_en = 1'b0;
  logic [4:0] prev;
  logic [4:0] exp_q[$];

  wash_state_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .CNT_W          (13)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .power_btn (power_btn),
    .start_btn (start_btn),
    .lid_open  (lid_open),
    .initTime  (initTime),
    .finishTime(finishTime),
    .hadFinish (hadFinish),
    .state     (state),
    .alarm     (alarm),
    .err_led   (err_led)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every change of the output tuple must match the next expectation.
  always @(negedge clk) begin
    logic [4:0] cur;
    logic [4:0] e;
    cur = {state, alarm, err_led};
    if (mon_en && (cur !== prev)) begin
      checks++;
      last_change_cyc = cyc;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_change: got state=%0d alarm=%0b err_led=%0b, no change expected",
                 state, alarm, err_led);
      end else begin
        e = exp_q.pop_front();
        if (cur !== e) begin
          errors++;
          $display("FAIL transition: got state=%0d alarm=%0b err_led=%0b, want state=%0d alarm=%0b err_led=%0b",
                   state, alarm, err_led, e[4:2], e[1], e[0]);
        end
      end
      prev = cur;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input logic [2:0] s, input logic a, input logic e);
    exp_q.push_back({s, a, e});
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick(1);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s: %0d expected transitions still pending, want 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_val(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  task automatic press_power();
    power_btn = 1'b1;
    tick(10);
    power_btn = 1'b0;
    tick(10);
  endtask

  task automatic press_start();
    start_btn = 1'b1;
    tick(10);
    start_btn = 1'b0;
    tick(10);
  endtask

  initial begin
    // Reset state
    tick(3);
    rst = 1'b0;
    tick(1);
    check_val("reset_state", int'(state), 0);
    check_val("reset_alarm", int'(alarm), 0);
    check_val("reset_err_led", int'(err_led), 0);
    prev = {state, alarm, err_led};
    mon_en = 1'b1;

    // A 3-cycle glitch must not be accepted.
    power_btn = 1'b1;
    tick(3);
    power_btn = 1'b0;
    tick(20);

    // Held press: exactly one pulse, mode changes 7 cycles after press start.
    expect_out(3'd1, 1'b0, 1'b0);
    t0 = cyc;
    press_power();
    wait_drain("power_on", 20);
    check_val("power_latency", last_change_cyc - t0, 7);

    // Begin countdown down to zero, set follows one cycle after zero.
    for (int v = 5; v >= 1; v--) begin
      initTime = 3'(v);
      tick(1);
    end
    expect_out(3'd2, 1'b0, 1'b0);
    t0 = cyc;
    initTime = 3'd0;
    wait_drain("begin_to_set", 10);
    check_val("set_latency", last_change_cyc - t0, 1);

    // set -> run -> pause -> run -> finish -> shutDown
    expect_out(3'd3, 1'b0, 1'b0);
    press_start();
    expect_out(3'd5, 1'b0, 1'b0);
    press_start();
    expect_out(3'd3, 1'b0, 1'b0);
    press_start();
    expect_out(3'd6, 1'b1, 1'b0);
    hadFinish = 1'b1;
    tick(2);
    hadFinish = 1'b0;
    wait_drain("to_finish", 10);
    expect_out(3'd0, 1'b0, 1'b0);
    finishTime = 3'd0;
    tick(2);
    finishTime = 3'd7;
    wait_drain("finish_to_off", 10);

    // Back to run; initTime is already zero so begin passes straight to set.
    expect_out(3'd1, 1'b0, 1'b0);
    expect_out(3'd2, 1'b0, 1'b0);
    press_power();
    expect_out(3'd3, 1'b0, 1'b0);
    press_start();

    // Lid open in run: error, start ignored, lid closed returns to pause.
    expect_out(3'd4, 1'b0, 1'b1);
    lid_open = 1'b1;
    tick(10);
    wait_drain("run_lid_error", 10);
    press_start();
    expect_out(3'd5, 1'b0, 1'b0);
    lid_open = 1'b0;
    tick(10);
    wait_drain("error_to_pause", 10);

    // Power cycle into set, then start with the lid open.
    expect_out(3'd0, 1'b0, 1'b0);
    press_power();
    expect_out(3'd1, 1'b0, 1'b0);
    expect_out(3'd2, 1'b0, 1'b0);
    press_power();
    lid_open = 1'b1;
    tick(10);
    expect_out(3'd4, 1'b0, 1'b1);
    press_start();
    expect_out(3'd2, 1'b0, 1'b0);
    lid_open = 1'b0;
    tick(10);
    wait_drain("error_to_set", 10);

    // In run, lid and hadFinish arrive at the FSM in the same cycle.
    expect_out(3'd3, 1'b0, 1'b0);
    press_start();
    expect_out(3'd4, 1'b0, 1'b1);
    lid_open = 1'b1;
    tick(6);
    hadFinish = 1'b1;
    tick(1);
    hadFinish = 1'b0;
    tick(3);
    wait_drain("lid_beats_finish", 10);
    expect_out(3'd5, 1'b0, 1'b0);
    lid_open = 1'b0;
    tick(10);

    // Power pulse coincides with hadFinish in run.
    expect_out(3'd3, 1'b0, 1'b0);
    press_start();
    expect_out(3'd0, 1'b0, 1'b0);
    power_btn = 1'b1;
    tick(6);
    hadFinish = 1'b1;
    tick(1);
    hadFinish = 1'b0;
    tick(3);
    power_btn = 1'b0;
    tick(10);
    wait_drain("power_beats_finish", 10);

    // Reset asserted in pause.
    expect_out(3'd1, 1'b0, 1'b0);
    expect_out(3'd2, 1'b0, 1'b0);
    press_power();
    expect_out(3'd3, 1'b0, 1'b0);
    press_start();
    expect_out(3'd5, 1'b0, 1'b0);
    press_start();
    wait_drain("reach_pause", 10);
    expect_out(3'd0, 1'b0, 1'b0);
    t0 = cyc;
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    wait_drain("reset_in_pause", 10);
    check_val("reset_latency", last_change_cyc - t0, 1);
    check_val("post_reset_state", int'(state), 0);
    check_val("post_reset_alarm", int'(alarm), 0);
    check_val("post_reset_err_led", int'(err_led), 0);
    tick(20);

    wait_drain("final_queue", 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
